qbert_move_sequencer: RTL and testbench
=======================================

QBERT_MOVE_SEQUENCER -- requirements
Module: qbert_move_sequencer

Interface
REQ-001 SHALL have parameter LOG2_STEPS, default 3: a move spans 2^LOG2_STEPS frames.
REQ-002 SHALL have parameter POS_W, default 21: position word is {x[20:10], y[9:0]}.
REQ-003 SHALL run on one clock; reset is synchronous and active-low.
REQ-004 iCLK  in  1  LCD pixel clock; the only clock.
REQ-005 iRST_n  in  1  synchronous active-low reset.
REQ-006 iStart  in  1  move request, level; the block acts on its rising edge.
REQ-007 iJump  in  3  direction: 0 up-right, 1 up-left, 2 down-right, 3 down-left; 4-7 invalid.
REQ-008 iEndFrame  in  1  one-cycle end-of-frame pulse.
REQ-009 iXLENGTH  in  11  horizontal displacement per jump (dx).
REQ-010 iYSTEP  in  10  vertical displacement per jump (dy).
REQ-011 iPOS_INIT  in  21  position to load.
REQ-012 iLoadPos  in  1  load iPOS_INIT into oPOS.
REQ-013 oPOS  out  21  current Qbert position {x,y}.
REQ-014 oBusy  out  1  move in progress.
REQ-015 oDone  out  1  last move completed.
REQ-016 oBad  out  1  last request rejected.

Function
REQ-017 SHALL detect the iStart rising edge against a registered copy of iStart, reset to 0.
REQ-018 SHALL implement states IDLE, WAIT_FRAME, STEP, DONE, BAD.
REQ-019 SHALL accept a start edge only in IDLE, DONE or BAD; the edge is ignored in WAIT_FRAME and STEP.
REQ-020 SHALL, on an accepted start with iJump>3, enter BAD with oBad=1 on the next cycle; oPOS is unchanged.
REQ-021 SHALL, on an accepted valid start, perform all of the following on the next cycle:
- latch target position
- latch step_x = iXLENGTH>>LOG2_STEPS and step_y = iYSTEP>>LOG2_STEPS
- clear step_cnt
- enter WAIT_FRAME with oBusy=1, oDone=0, oBad=0.
REQ-022 Target: x±dx (+ for jumps 0 and 2), y∓dy (- for jumps 0 and 1); modulo 2^11 for x and 2^10 for y.
REQ-023 SHALL ignore an iEndFrame that coincides with the accepted start cycle; the first step waits for the next pulse.
REQ-024 SHALL move from WAIT_FRAME to STEP on iEndFrame; STEP lasts exactly one cycle.
REQ-025 SHALL, in STEP, add the signed step_x/step_y to oPOS and increment step_cnt.
REQ-026 SHALL, in the STEP where step_cnt reaches 2^LOG2_STEPS, load the exact target into oPOS to absorb truncation, then enter DONE.
REQ-027 SHALL return from STEP to WAIT_FRAME when step_cnt has not yet reached 2^LOG2_STEPS.
REQ-028 SHALL hold oDone=1 in DONE and oBad=1 in BAD until the next accepted start or iLoadPos.
REQ-029 SHALL, on iLoadPos in IDLE/DONE/BAD, load oPOS next cycle, clear oDone/oBad and enter IDLE; iLoadPos is ignored while busy.
REQ-030 SHALL give iLoadPos priority over a start edge in the same cycle; that start edge is discarded.

Reset
REQ-031 SHALL, with iRST_n low at a clock edge, force all of the following, including mid-move:
- state=IDLE
- oPOS=0
- oBusy=0, oDone=0, oBad=0
- step_cnt=0
- start-edge register=0.
REQ-032 SHALL NOT report an iStart already high when reset releases as an edge.

Configuration
REQ-033 Macro QBERT_BOUNDS_CHECK_EN defined: SHALL compute the target with one extra bit; target x>799, y>479 or underflow SHALL be treated as invalid per REQ-020.
REQ-034 Macro QBERT_BOUNDS_CHECK_EN undefined: SHALL NOT bounds-check; targets wrap per REQ-022.

Verification
REQ-035 Normal move: oPOS=(100,50), XLENGTH=64, YSTEP=48, jump 2 -> first step (108,56); after 8 iEndFrame pulses (164,98), oDone=1, oBusy=0.
REQ-036 Invalid jump: jump 5 start edge -> oBad=1 next cycle, oPOS unchanged, oBusy stays 0.
REQ-037 Busy collision: second start edge at frame 3 of a move -> ignored; move completes at frame 8 with the original target.
REQ-038 Coincidence: start edge and iEndFrame in the same cycle -> oPOS unchanged until the next iEndFrame.
REQ-039 Reset mid-move: iRST_n low at frame 4 -> next cycle oPOS=0, oBusy=0, state IDLE.
REQ-040 Bounds: x=10, XLENGTH=64, jump 1 -> with macro oBad=1; without macro completes at x=1994.

Source files
------------

// File: rtl/qbert_move_sequencer_if.sv
// Handshake/bus bundle for qbert_move_sequencer: move request, frame timing,
// jump geometry and the position/status outputs.
interface qbert_move_sequencer_if #(
  parameter int POS_W = 21
);
  localparam int Y_W = 10;
  localparam int X_W = POS_W - Y_W;

  logic             iStart;
  logic [2:0]       iJump;
  logic             iEndFrame;
  logic [X_W-1:0]   iXLENGTH;
  logic [Y_W-1:0]   iYSTEP;
  logic [POS_W-1:0] iPOS_INIT;
  logic             iLoadPos;
  logic [POS_W-1:0] oPOS;
  logic             oBusy;
  logic             oDone;
  logic             oBad;

  // Master drives requests and geometry, observes position and status
  modport master (
    output iStart, iJump, iEndFrame, iXLENGTH, iYSTEP, iPOS_INIT, iLoadPos,
    input  oPOS, oBusy, oDone, oBad
  );

  // Slave is the sequencer itself
  modport slave (
    input  iStart, iJump, iEndFrame, iXLENGTH, iYSTEP, iPOS_INIT, iLoadPos,
    output oPOS, oBusy, oDone, oBad
  );
endinterface

// File: rtl/qbert_move_sequencer.sv
// Qbert jump sequencer: splits one diagonal jump into 2^LOG2_STEPS per-frame steps
// and lands exactly on the target. Optional macro QBERT_BOUNDS_CHECK_EN rejects off-screen targets.
module qbert_move_sequencer #(
  parameter int LOG2_STEPS = 3,
  parameter int POS_W      = 21
) (
  input logic                   iCLK,
  input logic                   iRST_n,
  qbert_move_sequencer_if.slave bus
);
  localparam int Y_W   = 10;
  localparam int X_W   = POS_W - Y_W;
  localparam int CNT_W = LOG2_STEPS + 1;
  localparam logic [CNT_W-1:0] STEPS_C = CNT_W'(1) << LOG2_STEPS;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_FRAME = 3'd1,
    STEP       = 3'd2,
    DONE       = 3'd3,
    BAD        = 3'd4
  } state_t;

  state_t           state_r;
  logic             start_d_r;
  logic             armed_r;
  logic [CNT_W-1:0] step_cnt_r;
  logic [X_W-1:0]   step_x_r;
  logic [Y_W-1:0]   step_y_r;
  logic [X_W-1:0]   tgt_x_r;
  logic [Y_W-1:0]   tgt_y_r;
  logic             x_neg_r;
  logic             y_neg_r;
  logic [POS_W-1:0] pos_r;
  logic             busy_r;
  logic             done_r;
  logic             bad_r;

  logic             start_edge_s;
  logic [X_W-1:0]   cur_x_s;
  logic [Y_W-1:0]   cur_y_s;
  logic             x_neg_s;
  logic             y_neg_s;
  logic [X_W-1:0]   nx_tgt_x_s;
  logic [Y_W-1:0]   nx_tgt_y_s;
  logic             out_of_bounds_s;
  logic             req_invalid_s;
  logic [X_W-1:0]   stepped_x_s;
  logic [Y_W-1:0]   stepped_y_s;
  logic [CNT_W-1:0] cnt_nx_s;

  function automatic logic [X_W-1:0] move_x(input logic [X_W-1:0] a,
                                            input logic [X_W-1:0] d,
                                            input logic           neg);
    if (neg) begin
      return a - d;
    end else begin
      return a + d;
    end
  endfunction

  function automatic logic [Y_W-1:0] move_y(input logic [Y_W-1:0] a,
                                            input logic [Y_W-1:0] d,
                                            input logic           neg);
    if (neg) begin
      return a - d;
    end else begin
      return a + d;
    end
  endfunction

  // armed_r masks the first cycle after reset so a held iStart is not taken as an edge
  always_comb begin
    start_edge_s = bus.iStart & ~start_d_r & armed_r;
    cur_x_s      = pos_r[POS_W-1:Y_W];
    cur_y_s      = pos_r[Y_W-1:0];
    x_neg_s      = bus.iJump[0];
    y_neg_s      = ~bus.iJump[1];
    stepped_x_s  = move_x(cur_x_s, step_x_r, x_neg_r);
    stepped_y_s  = move_y(cur_y_s, step_y_r, y_neg_r);
    cnt_nx_s     = step_cnt_r + CNT_W'(1);
  end

`ifdef QBERT_BOUNDS_CHECK_EN
  logic [X_W:0] ext_x_s;
  logic [Y_W:0] ext_y_s;

  // The extra bit catches underflow as a large value, so one compare covers both edges
  always_comb begin
    if (x_neg_s) begin
      ext_x_s = {1'b0, cur_x_s} - {1'b0, bus.iXLENGTH};
    end else begin
      ext_x_s = {1'b0, cur_x_s} + {1'b0, bus.iXLENGTH};
    end
    if (y_neg_s) begin
      ext_y_s = {1'b0, cur_y_s} - {1'b0, bus.iYSTEP};
    end else begin
      ext_y_s = {1'b0, cur_y_s} + {1'b0, bus.iYSTEP};
    end
    nx_tgt_x_s      = ext_x_s[X_W-1:0];
    nx_tgt_y_s      = ext_y_s[Y_W-1:0];
    out_of_bounds_s = (ext_x_s > (X_W+1)'(799)) || (ext_y_s > (Y_W+1)'(479));
  end
`else
  // Without bounds checking the target simply wraps in its field width
  always_comb begin
    nx_tgt_x_s      = move_x(cur_x_s, bus.iXLENGTH, x_neg_s);
    nx_tgt_y_s      = move_y(cur_y_s, bus.iYSTEP, y_neg_s);
    out_of_bounds_s = 1'b0;
  end
`endif

  always_comb begin
    req_invalid_s = bus.iJump[2] | out_of_bounds_s;
  end

  // Sequencer state, latched move geometry and registered outputs
  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      state_r    <= IDLE;
      start_d_r  <= 1'b0;
      armed_r    <= 1'b0;
      step_cnt_r <= '0;
      step_x_r   <= '0;
      step_y_r   <= '0;
      tgt_x_r    <= '0;
      tgt_y_r    <= '0;
      x_neg_r    <= 1'b0;
      y_neg_r    <= 1'b0;
      pos_r      <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      bad_r      <= 1'b0;
    end else begin
      start_d_r <= bus.iStart;
      armed_r   <= 1'b1;
      case (state_r)
        IDLE, DONE, BAD: begin
          if (bus.iLoadPos) begin
            pos_r   <= bus.iPOS_INIT;
            done_r  <= 1'b0;
            bad_r   <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else if (start_edge_s) begin
            if (req_invalid_s) begin
              bad_r   <= 1'b1;
              done_r  <= 1'b0;
              busy_r  <= 1'b0;
              state_r <= BAD;
            end else begin
              tgt_x_r    <= nx_tgt_x_s;
              tgt_y_r    <= nx_tgt_y_s;
              x_neg_r    <= x_neg_s;
              y_neg_r    <= y_neg_s;
              step_x_r   <= bus.iXLENGTH >> LOG2_STEPS;
              step_y_r   <= bus.iYSTEP >> LOG2_STEPS;
              step_cnt_r <= '0;
              busy_r     <= 1'b1;
              done_r     <= 1'b0;
              bad_r      <= 1'b0;
              state_r    <= WAIT_FRAME;
            end
          end
        end
        WAIT_FRAME: begin
          if (bus.iEndFrame) begin
            state_r <= STEP;
          end
        end
        STEP: begin
          step_cnt_r <= cnt_nx_s;
          if (cnt_nx_s == STEPS_C) begin
            // Final step lands on the exact target, absorbing the shift truncation
            pos_r   <= {tgt_x_r, tgt_y_r};
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            pos_r   <= {stepped_x_s, stepped_y_s};
            state_r <= WAIT_FRAME;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          bad_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oPOS  = pos_r;
  assign bus.oBusy = busy_r;
  assign bus.oDone = done_r;
  assign bus.oBad  = bad_r;

endmodule

// File: tb/tb_qbert_move_sequencer.sv
// Bench for qbert_move_sequencer: table of whole-move scenarios, hand-written corner
// sequences, then random stimulus against a frame-counting reference model.
module tb_qbert_move_sequencer;
  localparam int STEPS = 8;

  logic clk;
  logic rst_n;

  qbert_move_sequencer_if #(.POS_W(21)) bus ();

  qbert_move_sequencer #(.LOG2_STEPS(3), .POS_W(21)) dut (
    .iCLK  (clk),
    .iRST_n(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: position tracked as integers, progress as a count of steps taken
  int m_x = 0, m_y = 0, m_sx = 0, m_sy = 0, m_tx = 0, m_ty = 0;
  int m_stx = 0, m_sty = 0, m_sgx = 1, m_sgy = 1, m_k = 0;
  bit m_busy = 0, m_done = 0, m_bad = 0, m_pend = 0, m_prev = 0, m_armed = 0;

  typedef struct {
    int x0, y0, dx, dy, jump;
    bit bad;
    int fx, fy, tx, ty;
  } move_t;

  move_t moves[9];

  function automatic int wrap(input int v, input int m);
    return ((v % m) + m) % m;
  endfunction

  function automatic logic [31:0] pk(input int x, input int y);
    logic [10:0] xs;
    logic [9:0]  ys;
    xs = 11'(x);
    ys = 10'(y);
    return {11'd0, xs, ys};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit edge_s, valid;
    int j, txr, tyr;
    if (!rst_n) begin
      m_x = 0; m_y = 0; m_busy = 0; m_done = 0; m_bad = 0;
      m_pend = 0; m_k = 0; m_prev = 0; m_armed = 0;
      return;
    end
    edge_s  = bus.iStart && !m_prev && m_armed;
    m_prev  = bus.iStart;
    m_armed = 1;
    if (m_busy) begin
      if (m_pend) begin
        m_pend = 0;
        m_k++;
        if (m_k == STEPS) begin
          m_x = m_tx; m_y = m_ty; m_busy = 0; m_done = 1;
        end else begin
          m_x = wrap(m_sx + m_sgx * m_k * m_stx, 2048);
          m_y = wrap(m_sy + m_sgy * m_k * m_sty, 1024);
        end
      end else if (bus.iEndFrame) begin
        m_pend = 1;
      end
    end else if (bus.iLoadPos) begin
      m_x = int'(bus.iPOS_INIT[20:10]);
      m_y = int'(bus.iPOS_INIT[9:0]);
      m_done = 0; m_bad = 0;
    end else if (edge_s) begin
      j   = int'(bus.iJump);
      m_sgx = (j == 0 || j == 2) ? 1 : -1;
      m_sgy = (j == 0 || j == 1) ? -1 : 1;
      txr = m_x + m_sgx * int'(bus.iXLENGTH);
      tyr = m_y + m_sgy * int'(bus.iYSTEP);
      valid = (j < 4);
`ifdef QBERT_BOUNDS_CHECK_EN
      if (txr < 0 || txr > 799 || tyr < 0 || tyr > 479) valid = 0;
`endif
      if (!valid) begin
        m_bad = 1; m_done = 0;
      end else begin
        m_sx = m_x; m_sy = m_y;
        m_tx = wrap(txr, 2048); m_ty = wrap(tyr, 1024);
        m_stx = int'(bus.iXLENGTH) / STEPS;
        m_sty = int'(bus.iYSTEP) / STEPS;
        m_k = 0; m_pend = 0; m_busy = 1; m_done = 0; m_bad = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model_pos", {11'd0, bus.oPOS}, pk(m_x, m_y));
    chk("model_flags", {29'd0, bus.oBusy, bus.oDone, bus.oBad}, {29'd0, m_busy, m_done, m_bad});
  endtask

  task automatic frame();
    bus.iEndFrame = 1'b1;
    tick();
    bus.iEndFrame = 1'b0;
    tick();
  endtask

  task automatic do_load(input int x, input int y);
    bus.iPOS_INIT = 21'(pk(x, y));
    bus.iLoadPos  = 1'b1;
    tick();
    bus.iLoadPos  = 1'b0;
  endtask

  task automatic launch(input int dx, input int dy, input int jump);
    bus.iXLENGTH = 11'(dx);
    bus.iYSTEP   = 10'(dy);
    bus.iJump    = 3'(jump);
    bus.iStart   = 1'b1;
    tick();
    bus.iStart   = 1'b0;
  endtask

  task automatic run_move(input move_t r);
    do_load(r.x0, r.y0);
    chk("load_pos", {11'd0, bus.oPOS}, pk(r.x0, r.y0));
    launch(r.dx, r.dy, r.jump);
    if (r.bad) begin
      chk("bad_flag", {31'd0, bus.oBad}, 32'd1);
      chk("bad_busy", {31'd0, bus.oBusy}, 32'd0);
      chk("bad_pos", {11'd0, bus.oPOS}, pk(r.x0, r.y0));
      tick();
    end else begin
      chk("accept_busy", {31'd0, bus.oBusy}, 32'd1);
      chk("accept_pos", {11'd0, bus.oPOS}, pk(r.x0, r.y0));
      frame();
      chk("first_step", {11'd0, bus.oPOS}, pk(r.fx, r.fy));
      for (int i = 1; i < STEPS; i++) frame();
      chk("final_pos", {11'd0, bus.oPOS}, pk(r.tx, r.ty));
      chk("final_done", {30'd0, bus.oDone, bus.oBusy}, 32'd2);
    end
  endtask

  initial begin
    moves[0] = '{100, 50, 64, 48, 2, 1'b0, 108, 56, 164, 98};
    moves[1] = '{500, 300, 100, 40, 0, 1'b0, 512, 295, 600, 260};
    moves[2] = '{500, 300, 100, 40, 1, 1'b0, 488, 295, 400, 260};
    moves[3] = '{500, 300, 100, 40, 3, 1'b0, 488, 305, 400, 340};
    moves[4] = '{200, 200, 0, 0, 5, 1'b1, 0, 0, 0, 0};
    moves[5] = '{300, 100, 70, 30, 2, 1'b0, 308, 103, 370, 130};
    moves[6] = '{321, 123, 16, 16, 7, 1'b1, 0, 0, 0, 0};
`ifdef QBERT_BOUNDS_CHECK_EN
    moves[7] = '{10, 20, 64, 8, 1, 1'b1, 0, 0, 0, 0};
    moves[8] = '{5, 5, 8, 16, 0, 1'b1, 0, 0, 0, 0};
`else
    moves[7] = '{10, 20, 64, 8, 1, 1'b0, 2, 19, 1994, 12};
    moves[8] = '{5, 5, 8, 16, 0, 1'b0, 6, 3, 13, 1013};
`endif

    rst_n = 1'b0;
    bus.iStart = 1'b0; bus.iJump = 3'd0; bus.iEndFrame = 1'b0;
    bus.iXLENGTH = 11'd0; bus.iYSTEP = 10'd0; bus.iPOS_INIT = 21'd0; bus.iLoadPos = 1'b0;
    tick();
    tick();
    chk("reset_state", {8'd0, bus.oPOS, bus.oBusy, bus.oDone, bus.oBad}, 32'd0);
    rst_n = 1'b1;
    tick();

    foreach (moves[i]) run_move(moves[i]);

    // Start edge coinciding with iEndFrame: first step waits for the next pulse
    do_load(100, 50);
    bus.iEndFrame = 1'b1;
    launch(64, 48, 2);
    bus.iEndFrame = 1'b0;
    chk("coinc_busy", {31'd0, bus.oBusy}, 32'd1);
    tick();
    tick();
    chk("coinc_hold", {11'd0, bus.oPOS}, pk(100, 50));
    frame();
    chk("coinc_first", {11'd0, bus.oPOS}, pk(108, 56));
    for (int i = 1; i < STEPS; i++) frame();
    chk("coinc_final", {11'd0, bus.oPOS}, pk(164, 98));

    // Busy collision and load while busy are both ignored
    do_load(100, 50);
    launch(64, 48, 2);
    bus.iPOS_INIT = 21'(pk(7, 7));
    bus.iLoadPos = 1'b1;
    tick();
    bus.iLoadPos = 1'b0;
    chk("busy_load_ignored", {11'd0, bus.oPOS}, pk(100, 50));
    for (int i = 0; i < 3; i++) frame();
    bus.iStart = 1'b1;
    bus.iJump  = 3'd1;
    for (int i = 3; i < STEPS; i++) frame();
    chk("collision_final", {11'd0, bus.oPOS}, pk(164, 98));
    chk("collision_done", {31'd0, bus.oDone}, 32'd1);
    bus.iStart = 1'b0;
    tick();

    // Load wins over a same-cycle start edge, which is then lost
    bus.iPOS_INIT = 21'(pk(300, 200));
    bus.iLoadPos = 1'b1;
    bus.iJump = 3'd0;
    bus.iStart = 1'b1;
    tick();
    bus.iLoadPos = 1'b0;
    chk("load_prio_pos", {11'd0, bus.oPOS}, pk(300, 200));
    chk("load_prio_flags", {29'd0, bus.oBusy, bus.oDone, bus.oBad}, 32'd0);
    tick();
    chk("load_prio_no_start", {31'd0, bus.oBusy}, 32'd0);
    bus.iStart = 1'b0;
    tick();

    // Reset mid-move with iStart held high through release
    do_load(100, 50);
    launch(64, 48, 2);
    for (int i = 0; i < 4; i++) frame();
    bus.iStart = 1'b1;
    rst_n = 1'b0;
    tick();
    chk("midreset", {8'd0, bus.oPOS, bus.oBusy, bus.oDone, bus.oBad}, 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("held_start_no_edge", {31'd0, bus.oBusy}, 32'd0);
    bus.iStart = 1'b0;
    tick();

    // Random traffic against the reference model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) bus.iStart = ~bus.iStart;
      bus.iJump     = 3'($urandom_range(0, 7));
      bus.iEndFrame = ($urandom_range(0, 2) == 0);
      bus.iLoadPos  = ($urandom_range(0, 15) == 0);
      rst_n         = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 7) == 0) begin
        bus.iXLENGTH  = 11'($urandom);
        bus.iYSTEP    = 10'($urandom);
        bus.iPOS_INIT = 21'(pk($urandom_range(0, 799), $urandom_range(0, 479)));
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
